pipeline_clk_gen: RTL and testbench
===================================

# pipeline_clk_gen

Multi-channel programmable clock generator. It is the parametrised successor to the fixed divide-by-18 CPU clock divider, and sits between the 100 MHz board clock and the pipeline CPU and its peripherals. Each channel divides `sysclk` by a divisor that can be reprogrammed at runtime, with these properties:
- new divisors take effect only at period boundaries, so no runt pulses;
- a channel can be stopped cleanly, parking its output high;
- each channel also emits a one-cycle `tick` enable.

With default parameters, after reset, channel 0 reproduces the old divider's waveform exactly.

## Interface
Reset is asynchronous and active-high. One clock domain: `sysclk`.

Parameters:
- `CHANNELS`, default 2: number of independent output channels (1..8).
- `CNT_W`, default 16: divisor and counter width.
- `RESET_DIV`, default 18: divisor loaded into every channel at reset. Must be ≥ 2.

Ports:
- `sysclk`, input, 1: system clock (100 MHz).
- `reset`, input, 1: asynchronous, active-high reset.
- `en`, input, CHANNELS: per-channel run enable.
- `cfg_valid`, input, 1: configuration request.
- `cfg_ch`, input, max(1,$clog2(CHANNELS)): target channel.
- `cfg_div`, input, CNT_W: requested divisor D.
- `cfg_ready`, output, 1: a request can be accepted this cycle.
- `cfg_err`, output, 1: one-cycle pulse when an accepted request is discarded.
- `clk`, output, CHANNELS: divided clock outputs, registered.
- `tick`, output, CHANNELS: one-cycle pulse per output period, registered.
- `running`, output, CHANNELS: channel is counting (not parked).

## Operation
- Per-channel state:
  - active divisor `div` (reset `RESET_DIV`);
  - phase counter `cnt` (0..div-1, reset 0);
  - pending divisor plus pending flag (reset: clear);
  - a RUN/PARK state.
- Waveform for divisor D:
  - high phase H = ceil(D/2) cycles, then low phase L = floor(D/2) cycles;
  - `clk`=1 while `cnt` < H, else 0;
  - `cnt` wraps from D-1 to 0.
- `tick`=1 exactly in the cycle where `cnt`==D-1, i.e. the last low cycle before `clk` rises.
- States:
  - RUN: counting.
    - If `en`=0 at a boundary (`cnt`==D-1), go to PARK with `cnt`=0.
    - If `en` is deasserted mid-period, the current period finishes completely.
  - PARK: `cnt` held at 0, `clk`=1, `tick`=0, `running`=0.
    - `en`=1 → RUN. `cnt` starts advancing the next cycle; the first high phase lasts H cycles counted from the enable cycle.
- Configuration handshake:
  - A request is accepted when `cfg_valid`&`cfg_ready`.
  - `cfg_ready` = !pending[`cfg_ch`] (combinational on `cfg_ch`). It is forced to 1 when `cfg_ch` ≥ CHANNELS, so that the error path can respond.
  - Accepted request with `cfg_div` < 2 or `cfg_ch` ≥ CHANNELS: discarded, `cfg_err`=1 the next cycle, no state change.
  - Otherwise the divisor is stored as pending. It is applied:
    - at the next boundary (`cnt`==D-1 → the new D governs from `cnt`=0 onward), or
    - on the next cycle if the channel is in PARK.
  - Pending is then cleared.
  - A request accepted in the boundary cycle itself is applied at that boundary.
- Divisor arithmetic is unsigned, CNT_W bits; D up to 2^CNT_W−1 is supported.

## Timing
- Reset values:
  - `clk` = all 1;
  - `tick`, `cfg_err` = 0;
  - `running` = all 1 (channels start in RUN regardless of `en`; `en` is sampled at the first boundary);
  - all counters 0, all divisors `RESET_DIV`, all pending flags clear.
- Asserting `reset` mid-operation immediately restores all of the above and discards pending divisors.
- After reset release, with D=18: `clk` is high for cycles 0–8, low for 9–17 (`tick` at cycle 17), and rises again at cycle 18.
- All outputs except `cfg_ready` are registered, with no combinational path from inputs.
- Divisor change latency: at most D_old cycles after acceptance while running; 1 cycle while parked.
- Channels are fully independent. Simultaneous requests cannot occur (single config port).

## Test plan
- Reset, `en`=all 1, no config → ch0 `clk` period 18 with high 9 / low 9; `tick` every 18 cycles, at the last low cycle.
- Accept `cfg_div`=5 on ch1 mid-period while running D=18 → the current 18-cycle period completes, then ch1 runs high 3 / low 2; `cfg_ready` (ch1) is low until the switch.
- Drop `en`[0] in the 3rd cycle of a high phase → the period completes; `clk`[0] parks at 1 and `running`[0]=0. Re-assert `en` → the first high phase is 9 cycles, then normal operation.
- Request `cfg_div`=1, then `cfg_ch`=CHANNELS → each produces a `cfg_err` pulse one cycle after acceptance; the waveforms are unchanged.
- Assert `reset` while ch1 has a pending divisor of 7 → after release, ch1 runs D=18 and the pending value is lost.
- Request `cfg_div`=2 on a parked channel → applied the next cycle; after enable, `clk` alternates 1/0 and `tick` is high on every other cycle.

Source files
------------

// File: rtl/pipeline_clk_gen.sv
// +----------------------------------------------------------------------+
// | pipeline_clk_gen: multi-channel runtime-programmable clock divider    |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module pipeline_clk_gen #(
  parameter int CHANNELS  = 2,
  parameter int CNT_W     = 16,
  parameter int RESET_DIV = 18
) (
  input  logic                                                sysclk,
  input  logic                                                reset,
  input  logic [CHANNELS-1:0]                                 en,
  input  logic                                                cfg_valid,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]  cfg_ch,
  input  logic [CNT_W-1:0]                                    cfg_div,
  output logic                                                cfg_ready,
  output logic                                                cfg_err,
  output logic [CHANNELS-1:0]                                 clk,
  output logic [CHANNELS-1:0]                                 tick,
  output logic [CHANNELS-1:0]                                 running
);

  localparam logic [0:0]       ST_RUN  = 1'b0;
  localparam logic [0:0]       ST_PARK = 1'b1;
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(RESET_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  logic [31:0]         ch_idx;
  logic                ch_ok;
  logic [CHANNELS-1:0] sel;
  logic [CHANNELS-1:0] pend;
  logic                accept;
  logic                bad;
  logic                good;

  // Out-of-range channels report ready so the error path can answer them.
  assign ch_idx    = 32'(cfg_ch);
  assign ch_ok     = ch_idx < 32'(CHANNELS);
  assign cfg_ready = !ch_ok || !(|(sel & pend));
  assign accept    = cfg_valid && cfg_ready;
  assign bad       = accept && (!ch_ok || (cfg_div < TWO));
  assign good      = accept && !bad;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= bad;
    end
  end

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [0:0]       state, state_n;
      logic [CNT_W-1:0] cnt, cnt_n;
      logic [CNT_W-1:0] div, div_n;
      logic [CNT_W-1:0] pdiv, pdiv_n;
      logic [CNT_W-1:0] half_n;
      logic             pend_q, pend_n;
      logic             clk_q, tick_q, run_q;
      logic             wr;

      assign sel[i]     = (ch_idx == 32'(i));
      assign wr         = good && sel[i];
      assign pend[i]    = pend_q;
      assign clk[i]     = clk_q;
      assign tick[i]    = tick_q;
      assign running[i] = run_q;

      always_comb begin
        state_n = state;
        cnt_n   = cnt;
        div_n   = div;
        pdiv_n  = pdiv;
        pend_n  = pend_q;
        if (wr) begin
          pend_n = 1'b1;
          pdiv_n = cfg_div;
        end
        if (state == ST_RUN) begin
          if (cnt == div - ONE) begin
            cnt_n = '0;
            if (pend_q) begin
              div_n  = pdiv;
              pend_n = 1'b0;
            end else if (wr) begin
              div_n  = cfg_div;
              pend_n = 1'b0;
            end
            if (!en[i]) begin
              state_n = ST_PARK;
            end
          end else begin
            cnt_n = cnt + ONE;
          end
        end else begin
          cnt_n = '0;
          if (wr) begin
            div_n  = cfg_div;
            pend_n = 1'b0;
          end
          // The enable cycle itself counts as the first high cycle.
          if (en[i]) begin
            state_n = ST_RUN;
            cnt_n   = ONE;
          end
        end
        half_n = (div_n >> 1) + {{(CNT_W-1){1'b0}}, div_n[0]};
      end

      always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
          state  <= ST_RUN;
          cnt    <= '0;
          div    <= DIV_RST;
          pdiv   <= '0;
          pend_q <= 1'b0;
          clk_q  <= 1'b1;
          tick_q <= 1'b0;
          run_q  <= 1'b1;
        end else begin
          state  <= state_n;
          cnt    <= cnt_n;
          div    <= div_n;
          pdiv   <= pdiv_n;
          pend_q <= pend_n;
          clk_q  <= (state_n == ST_PARK) || (cnt_n < half_n);
          tick_q <= (state_n == ST_RUN) && (cnt_n == div_n - ONE);
          run_q  <= (state_n == ST_RUN);
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pipeline_clk_gen.sv
// +----------------------------------------------------------------------+
// | tb_pipeline_clk_gen: directed self-checking bench for pipeline_clk_gen|
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_clk_gen;

  localparam int CH = 3;
  localparam int W  = 16;

  logic          sysclk = 1'b0;
  logic          reset;
  logic [CH-1:0] en;
  logic          cfg_valid;
  logic [1:0]    cfg_ch;
  logic [W-1:0]  cfg_div;
  logic          cfg_ready;
  logic          cfg_err;
  logic [CH-1:0] clk;
  logic [CH-1:0] tick;
  logic [CH-1:0] running;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 sysclk = ~sysclk;

  pipeline_clk_gen #(
    .CHANNELS (CH),
    .CNT_W    (W),
    .RESET_DIV(18)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .clk      (clk),
    .tick     (tick),
    .running  (running)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
    cyc++;
  endtask

  // Running channel with period d that started its cnt=0 cycle at 'base'.
  task automatic chk_ch(input int ch, input int base, input int d);
    int j;
    int h;
    j = cyc - base;
    h = (d + 1) / 2;
    check($sformatf("clk%0d", ch),  clk[ch],  32'((j % d) < h));
    check($sformatf("tick%0d", ch), tick[ch], 32'((j % d) == d - 1));
    check($sformatf("run%0d", ch),  running[ch], 32'd1);
  endtask

  task automatic chk_park(input int ch);
    check($sformatf("pclk%0d", ch),  clk[ch],     32'd1);
    check($sformatf("ptick%0d", ch), tick[ch],    32'd0);
    check($sformatf("prun%0d", ch),  running[ch], 32'd0);
  endtask

  initial begin
    int rbase;
    int ebase;
    reset     = 1'b1;
    en        = 3'b111;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_div   = '0;
    repeat (3) step();

    check("rst_clk",   clk,       32'h7);
    check("rst_tick",  tick,      32'h0);
    check("rst_run",   running,   32'h7);
    check("rst_err",   cfg_err,   32'h0);
    check("rst_ready", cfg_ready, 32'h1);

    // Default divide-by-18 waveform from reset release.
    reset = 1'b0;
    cyc   = 0;
    while (cyc < 40) begin
      chk_ch(0, 0, 18);
      chk_ch(1, 0, 18);
      step();
    end

    // Reprogram ch1 to 5 mid-period.
    cfg_valid = 1'b1;
    cfg_ch    = 2'd1;
    cfg_div   = 16'd5;
    #1;
    check("ready_pre", cfg_ready, 32'd1);
    chk_ch(1, 0, 18);
    step();
    cfg_valid = 1'b0;
    while (cyc < 54) begin
      check("ready_pend", cfg_ready, 32'd0);
      chk_ch(0, 0, 18);
      chk_ch(1, 0, 18);
      step();
    end
    check("ready_post", cfg_ready, 32'd1);
    while (cyc < 74) begin
      chk_ch(0, 0, 18);
      chk_ch(1, 54, 5);
      step();
    end

    // Drop en[0] in the third high cycle; period must complete then park.
    en[0] = 1'b0;
    while (cyc < 90) begin
      chk_ch(0, 0, 18);
      chk_ch(1, 54, 5);
      step();
    end
    while (cyc < 95) begin
      chk_park(0);
      chk_ch(1, 54, 5);
      step();
    end
    en[0] = 1'b1;
    chk_park(0);
    step();
    while (cyc < 131) begin
      chk_ch(0, 95, 18);
      chk_ch(1, 54, 5);
      step();
    end

    // Illegal divisor, then out-of-range channel.
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_div   = 16'd1;
    #1;
    check("ready_d1", cfg_ready, 32'd1);
    step();
    cfg_valid = 1'b0;
    check("err_d1", cfg_err, 32'd1);
    check("ready_after_d1", cfg_ready, 32'd1);
    chk_ch(0, 95, 18);
    step();
    check("err_d1_clr", cfg_err, 32'd0);
    cfg_valid = 1'b1;
    cfg_ch    = 2'd3;
    cfg_div   = 16'd9;
    #1;
    check("ready_ch3", cfg_ready, 32'd1);
    step();
    cfg_valid = 1'b0;
    check("err_ch3", cfg_err, 32'd1);
    step();
    check("err_ch3_clr", cfg_err, 32'd0);
    while (cyc < 160) begin
      chk_ch(0, 95, 18);
      chk_ch(1, 54, 5);
      step();
    end

    // Reset while ch1 holds a pending divisor of 7.
    while (((cyc - 54) % 5) != 0) step();
    cfg_valid = 1'b1;
    cfg_ch    = 2'd1;
    cfg_div   = 16'd7;
    step();
    cfg_valid = 1'b0;
    check("ready_pend7", cfg_ready, 32'd0);
    reset = 1'b1;
    #1;
    check("arst_clk",   clk,       32'h7);
    check("arst_run",   running,   32'h7);
    check("arst_tick",  tick,      32'h0);
    check("arst_ready", cfg_ready, 32'd1);
    en = 3'b011;
    step();
    step();
    reset = 1'b0;
    rbase = cyc;
    while (cyc < rbase + 20) begin
      chk_ch(1, rbase, 18);
      if (cyc < rbase + 18) chk_ch(2, rbase, 18);
      else                  chk_park(2);
      step();
    end

    // Divisor 2 on parked ch2 applies at once; then enable.
    cfg_valid = 1'b1;
    cfg_ch    = 2'd2;
    cfg_div   = 16'd2;
    #1;
    check("ready_park", cfg_ready, 32'd1);
    step();
    cfg_valid = 1'b0;
    check("ready_park_post", cfg_ready, 32'd1);
    chk_park(2);
    step();
    en[2] = 1'b1;
    ebase = cyc;
    chk_park(2);
    step();
    while (cyc < ebase + 10) begin
      chk_ch(2, ebase, 2);
      chk_ch(1, rbase, 18);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
